// File: rtl/mac_pkg.sv
// Shared definitions for the MAC engine: register offsets, FSM states and job configuration.
package mac_package;

  // Word offsets, decoded from periph_add[7:2]
  localparam logic [5:0] REG_TRIGGER = 6'h00;
  localparam logic [5:0] REG_STATUS  = 6'h03;
  localparam logic [5:0] REG_A_ADDR  = 6'h08;
  localparam logic [5:0] REG_B_ADDR  = 6'h09;
  localparam logic [5:0] REG_C_ADDR  = 6'h0A;
  localparam logic [5:0] REG_D_ADDR  = 6'h0B;
  localparam logic [5:0] REG_LEN     = 6'h0C;
  localparam logic [5:0] REG_SHIFT   = 6'h0D;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  typedef struct packed {
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic [31:0] c_addr;
    logic [31:0] d_addr;
    logic [31:0] len;
    logic [4:0]  shift;
  } cfg_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/mac_engine.sv
// Combinational datapath: d = c + ((a*b) >>> shift). MAC_SATURATE_EN clamps the result to 32-bit signed range.
module mac_engine
  import mac_package::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [4:0]  shift,
  output logic [31:0] d
);

  localparam logic signed [63:0] MAX_S32 = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] MIN_S32 = 64'shFFFF_FFFF_8000_0000;

  logic signed [63:0] prod, shifted, sum;

  always_comb begin
    prod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    shifted = prod >>> shift;
    sum     = shifted + $signed({{32{c[31]}}, c});
`ifdef MAC_SATURATE_EN
    if (sum > MAX_S32)      d = 32'h7FFF_FFFF;
    else if (sum < MIN_S32) d = 32'h8000_0000;
    else                    d = sum[31:0];
`else
    d = sum[31:0];
`endif
  end

endmodule

// File: rtl/mac_top.sv
// MAC HWPE top: peripheral register file, job FSM and TCDM port control.
// Optional result saturation is selected with MAC_SATURATE_EN (see mac_engine).
module mac_top
  import mac_package::*;
#(
  parameter int unsigned N_CORES = 8,
  parameter int unsigned MP      = 4,
  parameter int unsigned ID      = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  output logic [MP-1:0]           tcdm_req,
  input  logic [MP-1:0]           tcdm_gnt,
  output logic [MP-1:0][31:0]     tcdm_add,
  output logic [MP-1:0]           tcdm_wen,
  output logic [MP-1:0][3:0]      tcdm_be,
  output logic [MP-1:0][31:0]     tcdm_data,
  input  logic [MP-1:0][31:0]     tcdm_r_data,
  input  logic [MP-1:0]           tcdm_r_valid,
  input  logic                    periph_req,
  output logic                    periph_gnt,
  input  logic [31:0]             periph_add,
  input  logic                    periph_wen,
  input  logic [3:0]              periph_be,
  input  logic [31:0]             periph_data,
  input  logic [ID-1:0]           periph_id,
  output logic [31:0]             periph_r_data,
  output logic                    periph_r_valid,
  output logic [ID-1:0]           periph_r_id,
  output logic [N_CORES-1:0][1:0] evt_o
);

  state_t            state, state_nx;
  cfg_t              cfg;
  logic [31:0]       idx;
  logic [2:0]        rd_pend, have, arrived;
  logic [2:0][31:0]  opnd;
  logic [31:0]       result, rdata, offs;
  logic [5:0]        reg_sel;
  logic              busy, wr, trigger, last;
  logic              unused;

  assign unused  = ^{test_mode_i, periph_add[31:8], periph_add[1:0],
                     tcdm_r_data[3], tcdm_r_valid[3]};

  assign reg_sel    = periph_add[7:2];
  assign busy       = (state != IDLE);
  assign wr         = periph_req && !periph_wen;
  assign trigger    = wr && (reg_sel == REG_TRIGGER) && !busy;
  assign last       = (idx == cfg.len - 32'd1);
  assign offs       = idx << 2;
  assign periph_gnt = periph_req;

  // An operand counts as arrived in the cycle its r_valid shows up, saving a cycle per element
  assign arrived = have | (tcdm_r_valid[2:0] & ~rd_pend);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (trigger) state_nx = (cfg.len == '0) ? DONE : LOAD;
      LOAD:    if (&arrived) state_nx = STORE;
      STORE:   if (tcdm_gnt[3]) state_nx = last ? DONE : LOAD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx     <= '0;
      rd_pend <= '0;
      have    <= '0;
      opnd    <= '0;
    end else begin
      if (trigger) idx <= '0;
      if (state == STORE && tcdm_gnt[3]) idx <= idx + 32'd1;
      if (state_nx == LOAD && state != LOAD) begin
        rd_pend <= '1;
        have    <= '0;
      end else if (state == LOAD) begin
        for (int unsigned p = 0; p < 3; p++) begin
          if (rd_pend[p] && tcdm_gnt[p]) rd_pend[p] <= 1'b0;
          else if (!rd_pend[p] && !have[p] && tcdm_r_valid[p]) begin
            opnd[p] <= tcdm_r_data[p];
            have[p] <= 1'b1;
          end
        end
      end
    end
  end

  mac_engine u_engine (
    .a     (opnd[0]),
    .b     (opnd[1]),
    .c     (opnd[2]),
    .shift (cfg.shift),
    .d     (result)
  );

  always_comb begin
    tcdm_req     = '0;
    tcdm_req[3]  = (state == STORE);
    for (int unsigned p = 0; p < 3; p++)
      tcdm_req[p] = (state == LOAD) && rd_pend[p];
    tcdm_add[0]  = cfg.a_addr + offs;
    tcdm_add[1]  = cfg.b_addr + offs;
    tcdm_add[2]  = cfg.c_addr + offs;
    tcdm_add[3]  = cfg.d_addr + offs;
    tcdm_wen     = 4'b0111;
    tcdm_be      = '1;
    tcdm_data    = '0;
    tcdm_data[3] = result;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg <= '0;
    end else if (wr && !busy) begin
      case (reg_sel)
        REG_A_ADDR: cfg.a_addr <= be_merge(cfg.a_addr, periph_data, periph_be);
        REG_B_ADDR: cfg.b_addr <= be_merge(cfg.b_addr, periph_data, periph_be);
        REG_C_ADDR: cfg.c_addr <= be_merge(cfg.c_addr, periph_data, periph_be);
        REG_D_ADDR: cfg.d_addr <= be_merge(cfg.d_addr, periph_data, periph_be);
        REG_LEN:    cfg.len    <= be_merge(cfg.len, periph_data, periph_be);
        REG_SHIFT:  if (periph_be[0]) cfg.shift <= periph_data[4:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata = {31'd0, busy};
      REG_A_ADDR: rdata = cfg.a_addr;
      REG_B_ADDR: rdata = cfg.b_addr;
      REG_C_ADDR: rdata = cfg.c_addr;
      REG_D_ADDR: rdata = cfg.d_addr;
      REG_LEN:    rdata = cfg.len;
      REG_SHIFT:  rdata = {27'd0, cfg.shift};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      periph_r_valid <= 1'b0;
      periph_r_id    <= '0;
      periph_r_data  <= '0;
    end else begin
      periph_r_valid <= periph_req;
      periph_r_id    <= periph_id;
      periph_r_data  <= (periph_req && periph_wen) ? rdata : '0;
    end
  end

  always_comb
    for (int unsigned k = 0; k < N_CORES; k++)
      evt_o[k] = {1'b0, state == DONE};

endmodule

// File: tb/tb_mac_top.sv
// Self-checking bench for mac_top: register access, table-driven single-element jobs, multi-cycle corner cases.
module tb_mac_top;

  localparam int unsigned N_CORES = 8;
  localparam int unsigned MP      = 4;
  localparam int unsigned ID      = 10;

  localparam logic [31:0] A_TRIG  = 32'h00, A_STATUS = 32'h0C, A_AADDR = 32'h20, A_BADDR = 32'h24;
  localparam logic [31:0] A_CADDR = 32'h28, A_DADDR  = 32'h2C, A_LEN   = 32'h30, A_SHIFT = 32'h34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MP-1:0]           tcdm_req;
  logic [MP-1:0]           tcdm_gnt = '0;
  logic [MP-1:0][31:0]     tcdm_add;
  logic [MP-1:0]           tcdm_wen;
  logic [MP-1:0][3:0]      tcdm_be;
  logic [MP-1:0][31:0]     tcdm_data;
  logic [MP-1:0][31:0]     tcdm_r_data = '0;
  logic [MP-1:0]           tcdm_r_valid = '0;
  logic                    periph_req = 1'b0;
  logic                    periph_gnt;
  logic [31:0]             periph_add = '0;
  logic                    periph_wen = 1'b1;
  logic [3:0]              periph_be = 4'hF;
  logic [31:0]             periph_data = '0;
  logic [ID-1:0]           periph_id = '0;
  logic [31:0]             periph_r_data;
  logic                    periph_r_valid;
  logic [ID-1:0]           periph_r_id;
  logic [N_CORES-1:0][1:0] evt_o;

  mac_top #(.N_CORES(N_CORES), .MP(MP), .ID(ID)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add), .periph_wen(periph_wen),
    .periph_be(periph_be), .periph_data(periph_data), .periph_id(periph_id),
    .periph_r_data(periph_r_data), .periph_r_valid(periph_r_valid), .periph_r_id(periph_r_id),
    .evt_o(evt_o)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0]     mem [0:255];
  logic            stall_en = 1'b0;
  int unsigned     gnt_wait [4];
  int unsigned     rv_cnt [4];
  logic [31:0]     rv_addr [4];
  logic [MP-1:0]   pend_prev = '0;
  logic [31:0]     add_prev [4];
  logic [31:0]     data_prev [4];
  int              proto_err = 0, req_cycles = 0, evt_cnt = 0, evt_bad = 0;

  // TCDM memory model with optional random grant and response latency
  always @(negedge clk) begin
    if (!rst_n) begin
      tcdm_gnt = '0;
      tcdm_r_valid = '0;
      pend_prev = '0;
      for (int p = 0; p < 4; p++) begin
        rv_cnt[p] = 0;
        gnt_wait[p] = 0;
      end
    end else begin
      if (|tcdm_req) req_cycles++;
      if (evt_o != '0) begin
        evt_cnt++;
        if (evt_o != {N_CORES{2'b01}}) evt_bad++;
      end
      for (int p = 0; p < 4; p++) begin
        tcdm_gnt[p] = 1'b0;
        tcdm_r_valid[p] = 1'b0;
        if (rv_cnt[p] != 0) begin
          rv_cnt[p]--;
          if (rv_cnt[p] == 0) begin
            tcdm_r_valid[p] = 1'b1;
            tcdm_r_data[p] = mem[rv_addr[p][9:2]];
          end
        end
        if (tcdm_req[p]) begin
          if (pend_prev[p] && (tcdm_add[p] != add_prev[p] || tcdm_data[p] != data_prev[p])) proto_err++;
          if (tcdm_wen[p] != (p < 3)) proto_err++;
          if (tcdm_be[p] != 4'hF) proto_err++;
          if (gnt_wait[p] == 0) begin
            tcdm_gnt[p] = 1'b1;
            if (p < 3) begin
              rv_addr[p] = tcdm_add[p];
              rv_cnt[p] = stall_en ? $urandom_range(3, 1) : 1;
            end else begin
              mem[tcdm_add[3][9:2]] = tcdm_data[3];
            end
            gnt_wait[p] = stall_en ? $urandom_range(5, 0) : 0;
            pend_prev[p] = 1'b0;
          end else begin
            gnt_wait[p]--;
            pend_prev[p] = 1'b1;
            add_prev[p] = tcdm_add[p];
            data_prev[p] = tcdm_data[p];
          end
        end else begin
          pend_prev[p] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pacc(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [ID-1:0] id,
                      output logic gnt, output logic rv, output logic [31:0] rd, output logic [ID-1:0] rid);
    @(negedge clk);
    periph_req = 1'b1; periph_wen = wen; periph_add = addr;
    periph_data = data; periph_be = be; periph_id = id;
    #1 gnt = periph_gnt;
    @(negedge clk);
    periph_req = 1'b0;
    rv = periph_r_valid; rd = periph_r_data; rid = periph_r_id;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic g, v; logic [31:0] d; logic [ID-1:0] i;
    pacc(1'b0, addr, data, 4'hF, '0, g, v, d, i);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic g, v; logic [ID-1:0] i;
    pacc(1'b1, addr, '0, 4'hF, '0, g, v, data, i);
  endtask

  task automatic setup_job(input logic [31:0] len, input logic [4:0] sh);
    wr(A_AADDR, 32'h000); wr(A_BADDR, 32'h080); wr(A_CADDR, 32'h100); wr(A_DADDR, 32'h180);
    wr(A_SHIFT, {27'd0, sh}); wr(A_LEN, len);
  endtask

  task automatic wait_done(input int e0, output int evts);
    for (int i = 0; i < 4000; i++) begin
      if (evt_cnt != e0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    evts = evt_cnt - e0;
  endtask

  function automatic logic [31:0] ref_mac(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [4:0] sh);
    longint p, s;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> sh;
    s = p + longint'($signed(c));
`ifdef MAC_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  typedef struct {
    logic [31:0] a, b, c;
    logic [4:0]  sh;
    logic [31:0] d;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic g, v;
    logic [31:0] d, exp_d;
    logic [ID-1:0] rid;
    int e0, evts, rq0;

    vecs[0] = '{32'd2, 32'd5, 32'd1, 5'd0, 32'd11};
    vecs[1] = '{32'hFFFF_FFFD, 32'd7, 32'd1, 5'd0, 32'hFFFF_FFEC};
    vecs[2] = '{32'h1_0000, 32'h1_0000, 32'd0, 5'd16, 32'h1_0000};
    vecs[3] = '{32'hFFFF_FFF8, 32'd1, 32'd0, 5'd2, 32'hFFFF_FFFE};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 5'd0, 32'hFFFF_FFFC};
    vecs[5] = '{32'd7, 32'd3, 32'd100, 5'd1, 32'd110};
    vecs[6] = '{32'hFFFF_FFF9, 32'd3, 32'd0, 5'd1, 32'hFFFF_FFF5};
`ifdef MAC_SATURATE_EN
    vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 5'd0, 32'h7FFF_FFFF};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 5'd31, 32'h7FFF_FFFF};
    vecs[9] = '{32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000};
`else
    vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 5'd0, 32'h0000_0001};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 5'd31, 32'h8000_0000};
    vecs[9] = '{32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h7FFF_FFFF};
`endif
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("reset tcdm_req", {28'd0, tcdm_req}, 32'd0);
    check("reset evt_o", {16'd0, evt_o}, 32'd0);
    check("reset r_valid", {31'd0, periph_r_valid}, 32'd0);
    rst_n = 1'b1;

    rd(A_STATUS, d); check("status idle", d, 32'd0);
    rd(A_LEN, d);    check("len reset", d, 32'd0);

    pacc(1'b0, A_AADDR, 32'h1000, 4'hF, 10'h3A, g, v, d, rid);
    check("write gnt", {31'd0, g}, 32'd1);
    check("write r_valid", {31'd0, v}, 32'd1);
    check("write r_id", {22'd0, rid}, 32'h3A);
    check("write r_data", d, 32'd0);
    pacc(1'b1, A_AADDR, '0, 4'hF, 10'h15, g, v, d, rid);
    check("read a_addr", d, 32'h1000);
    check("read r_id", {22'd0, rid}, 32'h15);
    pacc(1'b0, A_AADDR, 32'hABCD_EF12, 4'b0100, '0, g, v, d, rid);
    rd(A_AADDR, d); check("byte enable", d, 32'h00CD_1000);
    rd(32'hFFFF_FF20, d); check("upper addr ignored", d, 32'h00CD_1000);
    wr(32'h3C, 32'hFFFF_FFFF);
    rd(32'h3C, d); check("unmapped read", d, 32'd0);

    for (int i = 0; i < 10; i++) begin
      mem[0] = vecs[i].a; mem[32] = vecs[i].b; mem[64] = vecs[i].c; mem[96] = 32'hDEAD_BEEF;
      setup_job(32'd1, vecs[i].sh);
      e0 = evt_cnt;
      wr(A_TRIG, 32'd1);
      wait_done(e0, evts);
      check($sformatf("vec%0d d", i), mem[96], vecs[i].d);
      check($sformatf("vec%0d events", i), evts, 32'd1);
    end

    mem[0] = 32'd2; mem[1] = 32'hFFFF_FFFD; mem[32] = 32'd5; mem[33] = 32'd7;
    mem[64] = 32'd1; mem[65] = 32'd1; mem[96] = '0; mem[97] = '0;
    setup_job(32'd2, 5'd0);
    e0 = evt_cnt;
    wr(A_TRIG, 32'd1);
    rd(A_STATUS, d); check("status busy", d, 32'd1);
    wr(A_BADDR, 32'h999);
    wait_done(e0, evts);
    check("basic d0", mem[96], 32'd11);
    check("basic d1", mem[97], 32'hFFFF_FFEC);
    check("basic events", evts, 32'd1);
    rd(A_STATUS, d); check("status after job", d, 32'd0);
    rd(A_BADDR, d);  check("write while busy ignored", d, 32'h080);

    stall_en = 1'b1;
    proto_err = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom; mem[32+i] = $urandom; mem[64+i] = $urandom; mem[96+i] = 32'hDEAD_BEEF;
    end
    setup_job(32'd16, 5'd7);
    e0 = evt_cnt;
    wr(A_TRIG, 32'd1);
    wait_done(e0, evts);
    for (int i = 0; i < 16; i++) begin
      exp_d = ref_mac(mem[i], mem[32+i], mem[64+i], 5'd7);
      check($sformatf("stall d%0d", i), mem[96+i], exp_d);
    end
    check("stall events", evts, 32'd1);
    check("stall handshake stability", proto_err, 32'd0);
    stall_en = 1'b0;

    wr(A_LEN, 32'd0);
    rq0 = req_cycles;
    e0 = evt_cnt;
    wr(A_TRIG, 32'd1);
    @(negedge clk);
    check("len0 event", evt_cnt - e0, 32'd1);
    repeat (4) @(negedge clk);
    check("len0 single event", evt_cnt - e0, 32'd1);
    check("len0 no tcdm traffic", req_cycles - rq0, 32'd0);
    check("event pattern", evt_bad, 32'd0);

    stall_en = 1'b1;
    setup_job(32'd16, 5'd0);
    wr(A_TRIG, 32'd1);
    repeat (12) @(negedge clk);
    e0 = evt_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("abort tcdm_req", {28'd0, tcdm_req}, 32'd0);
    check("abort evt_o", {16'd0, evt_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stall_en = 1'b0;
    repeat (6) @(negedge clk);
    check("abort no event", evt_cnt - e0, 32'd0);
    rd(A_STATUS, d); check("abort status", d, 32'd0);
    rd(A_LEN, d);    check("abort len cleared", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
